// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch with credit-limited requests and a DEPTH-entry decode FIFO (optional FQ_PERF_EN starve counter)
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
`ifdef FQ_PERF_EN
  ,
  output logic [31:0] perf_starve_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [AW-1:0] q_wr, q_rd;
  logic [AW:0]   q_cnt;
  logic [31:0]   a_pc    [DEPTH];
  logic [AW-1:0] a_wr, a_rd;
  logic [AW:0]   a_cnt;
  logic [CW-1:0] out_cnt, drop_cnt;
  logic [AW+1:0] credit;
  logic          req_fire, rsp_ok, rsp_keep, pop;
  // a_cnt tracks only live (non-dropped) requests, so occupancy plus a_cnt is the credit in use
  always_comb begin
    credit         = {1'b0, q_cnt} + {1'b0, a_cnt};
    imem_req_valid = !res && !redirect_valid && (credit < (AW+2)'(DEPTH));
    imem_req_addr  = res ? 32'h0 : fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_ok         = imem_rsp_valid && (out_cnt != '0);
    rsp_keep       = rsp_ok && (drop_cnt == '0) && !redirect_valid;
    if_valid       = !res && !redirect_valid && (q_cnt != '0);
    if_pc          = res ? 32'h0 : q_pc[q_rd];
    if_instr       = res ? 32'h0 : q_instr[q_rd];
    pop            = if_valid && if_ready;
  end
  // storage for issued addresses and buffered {pc, instr} entries
  always_ff @(posedge clk) begin
    if (req_fire) a_pc[a_wr] <= fetch_pc;
    if (rsp_keep) begin
      q_pc[q_wr]    <= a_pc[a_rd];
      q_instr[q_wr] <= imem_rsp_data;
    end
  end
  // fetch address, pointers, in-flight and drop counters; redirect outranks everything but reset
  always_ff @(posedge clk) begin
    if (res) begin
      fetch_pc <= RESET_PC;
      q_wr     <= '0;
      q_rd     <= '0;
      q_cnt    <= '0;
      a_wr     <= '0;
      a_rd     <= '0;
      a_cnt    <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'h3;
      q_wr     <= '0;
      q_rd     <= '0;
      q_cnt    <= '0;
      a_wr     <= '0;
      a_rd     <= '0;
      a_cnt    <= '0;
      out_cnt  <= out_cnt - CW'(rsp_ok);
      drop_cnt <= out_cnt - CW'(rsp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
        a_wr     <= a_wr + AW'(1);
      end
      if (rsp_keep) begin
        a_rd <= a_rd + AW'(1);
        q_wr <= q_wr + AW'(1);
      end
      if (pop) q_rd <= q_rd + AW'(1);
      a_cnt    <= a_cnt + (AW+1)'(req_fire) - (AW+1)'(rsp_keep);
      q_cnt    <= q_cnt + (AW+1)'(rsp_keep) - (AW+1)'(pop);
      out_cnt  <= out_cnt + CW'(req_fire) - CW'(rsp_ok);
      drop_cnt <= drop_cnt - CW'(rsp_ok && (drop_cnt != '0));
    end
  end
`ifdef FQ_PERF_EN
  // counts cycles where decode was ready but nothing was buffered
  always_ff @(posedge clk) begin
    if (res) perf_starve_cnt <= '0;
    else if (if_ready && (q_cnt == '0) && !redirect_valid) perf_starve_cnt <= perf_starve_cnt + 32'd1;
  end
`endif
  rsp_without_req: assert property (@(posedge clk) disable iff (res) !(imem_rsp_valid && (out_cnt == '0)));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue against a program-order fetch model
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        if_ready = 1'b0;
`ifdef FQ_PERF_EN
  logic [31:0] perf_starve_cnt;
`endif
  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .res(res), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
`ifdef FQ_PERF_EN
    , .perf_starve_cnt(perf_starve_cnt)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0;
  int lat = 1, p_rr = 100, p_ir = 100;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [63:0] exp_q[$];
  logic [31:0] next_req_pc = RESET_PC;
  int acc_since = 0, pop_since = 0, acc_total = 0, pop_total = 0, first_pop_cyc = -1;
  logic [31:0] first_pop_pc = 32'hDEADBEEF;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: model of the fetch stream, credit limit and memory request log
  always begin
    logic [63:0] e;
    logic        exp_rv;
    @(negedge clk);
    #2;
    if (res) begin
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_req_addr", imem_req_addr, 0);
      check("rst_if_valid", if_valid, 0);
      check("rst_if_pc", if_pc, 0);
      check("rst_if_instr", if_instr, 0);
      exp_q.delete();
      mq_addr.delete();
      mq_due.delete();
      next_req_pc = RESET_PC;
      acc_since = 0;
      pop_since = 0;
    end else begin
      exp_rv = !redirect_valid && ((acc_since - pop_since) < DEPTH);
      check("credit_req_valid", imem_req_valid, exp_rv);
      if (redirect_valid) check("redirect_if_valid", if_valid, 0);
      if (if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_pop: got pc %0h expected no entry", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("if_pc", if_pc, e[63:32]);
          check("if_instr", if_instr, e[31:0]);
        end
        pop_since++;
        pop_total++;
        if (first_pop_cyc < 0) begin
          first_pop_cyc = cyc;
          first_pop_pc  = if_pc;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, next_req_pc);
        exp_q.push_back({next_req_pc, mem_f(next_req_pc)});
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
        next_req_pc += 32'd4;
        acc_since++;
        acc_total++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        acc_since = 0;
        pop_since = 0;
        next_req_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end
  task automatic step(input bit r, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    cyc++;
    res            = r;
    redirect_valid = rd;
    redirect_pc    = rpc;
    if_ready       = $urandom_range(99) < p_ir;
    imem_req_ready = $urandom_range(99) < p_rr;
    if (!r && mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_f(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask
  task automatic do_reset();
    repeat (2) step(1, 0, 0);
  endtask
  initial begin
    int t0;
    // 1: one-cycle memory, decode always ready
    lat = 1; p_rr = 100; p_ir = 100;
    do_reset();
    t0 = cyc + 1;
    first_pop_cyc = -1;
    pop_total = 0;
    repeat (10) step(0, 0, 0);
    #3;
    check("t1_first_pop_cycle", first_pop_cyc - t0, 2);
    check("t1_pop_count", pop_total, 8);
    // 2: decode stalled, credit stops at DEPTH
    p_ir = 0;
    do_reset();
    acc_total = 0;
    repeat (10) step(0, 0, 0);
    #3;
    check("t2_accepted", acc_total, 4);
    check("t2_req_valid_low", imem_req_valid, 0);
    p_ir = 100;
    pop_total = 0;
    repeat (12) step(0, 0, 0);
    #3;
    check("t2_pops_ge5", pop_total >= 5, 1);
    // 3: latency 3, redirect with two requests in flight
    lat = 3; p_rr = 100; p_ir = 100;
    do_reset();
    repeat (2) step(0, 0, 0);
    p_rr = 0;
    first_pop_cyc = -1;
    first_pop_pc = 32'hDEADBEEF;
    step(0, 1, 32'h100);
    p_rr = 100;
    repeat (12) step(0, 0, 0);
    #3;
    check("t3_first_pc", first_pop_pc, 32'h100);
    // 4: misaligned redirect near the top of the address space wraps to 0
    lat = 1;
    do_reset();
    repeat (2) step(0, 0, 0);
    first_pop_cyc = -1;
    first_pop_pc = 32'hDEADBEEF;
    step(0, 1, 32'hFFFFFFFE);
    repeat (8) step(0, 0, 0);
    #3;
    check("t4_first_pc", first_pop_pc, 32'hFFFFFFFC);
    // 5: random ready on both sides, random redirects, one mid-run reset
    lat = 2; p_rr = 50; p_ir = 50;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) step(1, 0, 0);
      else step(0, $urandom_range(99) < 3, $urandom);
    end
    p_rr = 0; p_ir = 100;
    repeat (20) step(0, 0, 0);
    #3;
    check("t5_drained", exp_q.size(), 0);
    check("t5_if_valid_idle", if_valid, 0);
`ifdef FQ_PERF_EN
    // 6: starve counter over five empty ready cycles, then reset
    p_rr = 0; p_ir = 100;
    do_reset();
    repeat (6) step(0, 0, 0);
    #3;
    check("t6_perf_cnt", perf_starve_cnt, 5);
    step(1, 0, 0);
    step(0, 0, 0);
    #3;
    check("t6_perf_reset", perf_starve_cnt, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
